// File: rtl/kpscan.sv
// kpscan: 4x4 keypad column scanner with tick-based press/release debounce.
// One column is driven low at a time. A non-idle row sample stops the scan
// and starts the press debounce. The key is then held until the release
// debounce sees idle rows for DB_TICKS consecutive ticks.
module kpscan #(
  parameter int SCAN_DIV = 50000,
  parameter int DB_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] kpr_db,
  output logic       key_down,
  output logic       key_press,
  output logic       key_release
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  // The sample that makes the count reach DB_TICKS arrives when db_cnt
  // already holds DB_TICKS-1, so the counter never has to hold DB_TICKS.
  localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);
  localparam logic [3:0]    IDLE    = 4'b1111;

  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_REL} state_t;

  state_t        state_q, state_d;
  logic [3:0]    kpr_m_q, kpr_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    kpc_q, kpc_d;
  logic [3:0]    kpr_db_q, kpr_db_d;
  logic          key_down_q, key_down_d;
  logic          key_press_q, key_press_d;
  logic          key_release_q, key_release_d;
  logic          tick, idle;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kpr_m_q <= IDLE;
      kpr_s_q <= IDLE;
    end else begin
      kpr_m_q <= kpr;
      kpr_s_q <= kpr_m_q;
    end
  end

  // Free-running scan tick divider.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Next-state and output logic. State changes happen only on tick cycles.
  always_comb begin
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    cap_d         = cap_q;
    kpc_d         = kpc_q;
    kpr_db_d      = kpr_db_q;
    key_down_d    = key_down_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    idle          = (kpr_s_q == IDLE);
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (idle) begin
            kpc_d = {kpc_q[0], kpc_q[3:1]};
          end else begin
            cap_d    = kpr_s_q;
            db_cnt_d = DW'(1);
            state_d  = DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (idle) begin
            // Bounce: back to scanning with the column unchanged this tick.
            db_cnt_d = '0;
            state_d  = SCAN;
          end else if (kpr_s_q != cap_q) begin
            cap_d    = kpr_s_q;
            db_cnt_d = DW'(1);
          end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d    = '0;
            kpr_db_d    = cap_q;
            key_down_d  = 1'b1;
            key_press_d = 1'b1;
            state_d     = HELD;
          end else begin
            db_cnt_d = db_cnt_q + DW'(1);
          end
        end
        HELD: begin
          // Other non-idle patterns (roll-over) are ignored while held.
          if (idle) begin
            db_cnt_d = DW'(1);
            state_d  = DB_REL;
          end
        end
        DB_REL: begin
          if (!idle) begin
            db_cnt_d = '0;
            state_d  = HELD;
          end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d      = '0;
            kpr_db_d      = IDLE;
            key_down_d    = 1'b0;
            key_release_d = 1'b1;
            state_d       = SCAN;
          end else begin
            db_cnt_d = db_cnt_q + DW'(1);
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SCAN;
      cnt_q         <= '0;
      db_cnt_q      <= '0;
      cap_q         <= IDLE;
      kpc_q         <= 4'b0111;
      kpr_db_q      <= IDLE;
      key_down_q    <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      db_cnt_q      <= db_cnt_d;
      cap_q         <= cap_d;
      kpc_q         <= kpc_d;
      kpr_db_q      <= kpr_db_d;
      key_down_q    <= key_down_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign kpc         = kpc_q;
  assign kpr_db      = kpr_db_q;
  assign key_down    = key_down_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule
